// File: rtl/freq_div_pkg.sv
// rtl/freq_div_pkg.sv - shared defaults and ratio helper for the cascaded divider
package freq_div_pkg;

    localparam int DIGIT_W_DEF    = 4;
    localparam int NUM_STAGES_DEF = 2;

    // Output-pulse spacing in clock cycles for a given preset and direction
    function automatic int ratio_f(input int load, input logic down, input int cw);
        if (down) begin
            return load + 1;
        end
        return (1 << cw) - load;
    endfunction

endpackage

// File: rtl/div_digit.sv
// rtl/div_digit.sv - one loadable up/down counter digit of the divider cascade
module div_digit
    import freq_div_pkg::*;
#(
    parameter int DIGIT_W = DIGIT_W_DEF
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               step_in,
    input  logic               down,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q,
    output logic               term
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (step_in) begin
            q_d = down ? (q_q - DIGIT_W'(1)) : (q_q + DIGIT_W'(1));
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            q_q <= d;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign term = down ? (q_q == '0) : (q_q == '1);

endmodule

// File: rtl/cascaded_freq_divider.sv
// rtl/cascaded_freq_divider.sv - programmable divider built from cascaded counter digits
module cascaded_freq_divider
    import freq_div_pkg::*;
#(
    parameter int  DIGIT_W    = DIGIT_W_DEF,
    parameter int  NUM_STAGES = NUM_STAGES_DEF,
    localparam int CW         = DIGIT_W * NUM_STAGES
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          EN,
    input  logic          DOWN,
    input  logic [CW-1:0] LOAD_VAL,
    input  logic          LD_NOW,
    output logic [CW-1:0] Q,
    output logic          CO,
    output logic          QOUT
);

    logic [NUM_STAGES-1:0] dig_term;
    logic [NUM_STAGES-1:0] step;
    logic                  term_all;
    logic                  reload;

    logic dn_q, dn_d;
    logic co_q, co_d;
    logic qout_q, qout_d;

    assign term_all = &dig_term;
    // The preset word itself needs no shadow copy: it is only read at reload instants.
    assign reload   = EN & (LD_NOW | term_all);

    always_comb begin
        step[0] = EN;
        for (int k = 1; k < NUM_STAGES; k++) begin
            step[k] = step[k-1] & dig_term[k-1];
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_digit
        div_digit #(.DIGIT_W(DIGIT_W)) u_digit (
            .CLK     (CLK),
            .CLR     (CLR),
            .step_in (step[k]),
            .down    (dn_q),
            .load    (reload),
            .d       (LOAD_VAL[k*DIGIT_W +: DIGIT_W]),
            .q       (Q[k*DIGIT_W +: DIGIT_W]),
            .term    (dig_term[k])
        );
    end

    always_comb begin
        dn_d   = dn_q;
        co_d   = 1'b0;
        qout_d = qout_q;
        if (EN) begin
            if (LD_NOW) begin
                dn_d = DOWN;
            end else if (term_all) begin
                dn_d   = DOWN;
                co_d   = 1'b1;
                qout_d = ~qout_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            dn_q   <= DOWN;
            co_q   <= 1'b0;
            qout_q <= 1'b0;
        end else begin
            dn_q   <= dn_d;
            co_q   <= co_d;
            qout_q <= qout_d;
        end
    end

    assign CO   = co_q;
    assign QOUT = qout_q;

endmodule

// File: tb/tb_cascaded_freq_divider.sv
// tb/tb_cascaded_freq_divider.sv - randomized self-checking bench for the cascaded divider
module tb_cascaded_freq_divider;

    localparam int CW   = 8;
    localparam int QMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          clr, en, down, ld_now;
    logic [CW-1:0] load_val;
    logic [CW-1:0] q;
    logic          co, qout;

    int n_vec  = 0;
    int n_miss = 0;

    // reference state: plain integer count plus period bookkeeping
    int m_q, m_co, m_qout, m_dn;
    int cyc, last_co, co_gap, min_gap;

    cascaded_freq_divider dut (
        .CLK      (clk),
        .CLR      (clr),
        .EN       (en),
        .DOWN     (down),
        .LOAD_VAL (load_val),
        .LD_NOW   (ld_now),
        .Q        (q),
        .CO       (co),
        .QOUT     (qout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int term;
        if (clr) begin
            m_q = load_val; m_dn = down; m_co = 0; m_qout = 0;
        end else if (en) begin
            term = m_dn ? (m_q == 0) : (m_q == QMAX);
            if (ld_now) begin
                m_q = load_val; m_dn = down; m_co = 0;
            end else if (term) begin
                m_q = load_val; m_dn = down; m_co = 1; m_qout = 1 - m_qout;
            end else begin
                m_q = m_dn ? m_q - 1 : m_q + 1;
                m_co = 0;
            end
        end else begin
            m_co = 0;
        end
    endtask

    task automatic step(input logic c, input logic e, input logic d,
                        input int lv, input logic ln);
        @(negedge clk);
        clr = c; en = e; down = d; load_val = CW'(lv); ld_now = ln;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        chk("q", int'(q), m_q);
        chk("co", int'(co), m_co);
        chk("qout", int'(qout), m_qout);
        if (co) begin
            if (last_co >= 0) begin
                co_gap = cyc - last_co;
                if (co_gap < min_gap) min_gap = co_gap;
            end
            last_co = cyc;
        end
    endtask

    task automatic restart_gap();
        last_co = -1; co_gap = -1; min_gap = 1 << 30;
    endtask

    initial begin
        int lv, dn;
        m_q = 0; m_co = 0; m_qout = 0; m_dn = 0; cyc = 0;
        restart_gap();

        // up mode 0x8F: pulse every 113 cycles
        step(1, 1, 0, 'h8F, 0);
        chk("reset_q", int'(q), 'h8F);
        for (int i = 0; i < 240; i++) step(0, 1, 0, 'h8F, 0);
        chk("up_8f_period", co_gap, 113);

        // down mode 0x09: pulse every 10 cycles
        step(0, 1, 1, 'h09, 1);
        restart_gap();
        for (int i = 0; i < 40; i++) step(0, 1, 1, 'h09, 0);
        chk("dn_09_period", co_gap, 10);

        // down across digit boundary, then preset change mid-period in up mode
        step(0, 1, 1, 'h11, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 'h11, 0);
        step(0, 1, 0, 'hF0, 1);
        restart_gap();
        for (int i = 0; i < 5; i++) step(0, 1, 0, 'hF0, 0);
        for (int i = 0; i < 30; i++) step(0, 1, 0, 'hFE, 0);
        chk("preset_change_min_gap", min_gap, 2);

        // ratio 1: CO held high, then LD_NOW on a terminal cycle
        step(0, 1, 0, 'hFF, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 'hFF, 0);
        chk("ratio1_co", int'(co), 1);
        step(0, 1, 0, 'hFF, 1);
        chk("ldnow_beats_term", int'(co), 0);

        // enable gap of 50 cycles mid-count stretches the period
        step(0, 1, 0, 'hC0, 1);
        restart_gap();
        for (int i = 0; i < 70; i++) step(0, 1, 0, 'hC0, 0);
        for (int i = 0; i < 50; i++) step(0, 0, 0, 'hC0, 0);
        for (int i = 0; i < 150; i++) step(0, 1, 0, 'hC0, 0);
        chk("en_gap_period", min_gap, 64);

        // reset mid-period, and reset together with LD_NOW
        for (int i = 0; i < 7; i++) step(0, 1, 0, 'h80, 0);
        step(1, 1, 1, 'h80, 0);
        chk("clr_q", int'(q), 'h80);
        chk("clr_qout", int'(qout), 0);
        step(1, 1, 0, 'h33, 1);
        chk("clr_ldnow_q", int'(q), 'h33);

        // randomized operation against the reference model
        lv = 'h40; dn = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                lv = $urandom_range(0, QMAX);
                dn = $urandom_range(0, 1);
            end
            step(logic'($urandom_range(0, 599) == 0),
                 logic'($urandom_range(0, 7) != 0),
                 logic'(dn), lv,
                 logic'($urandom_range(0, 79) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
